// File: rtl/tdm_demux8.sv
// 8-slot TDM receive demultiplexer: collects one frame of samples into a shadow
// buffer and publishes all eight lanes together when slot 7 is accepted.
module tdm_demux8 #(
    parameter int WIDTH      = 1,
    parameter int SYNC_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 sync,
    output logic [2:0]           s,
    output logic                 locked,
    output logic [8*WIDTH-1:0]   y,
    output logic                 frame_valid,
    output logic                 sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_slot;
    logic [2:0]           w_slot_nxt;
    logic [8*WIDTH-1:0]   r_shadow;
    logic [8*WIDTH-1:0]   w_shadow_nxt;
    logic [8*WIDTH-1:0]   r_y;
    logic [8*WIDTH-1:0]   w_y_nxt;
    logic                 r_frame_valid;
    logic                 w_frame_valid_nxt;
    logic                 r_sync_err;
    logic                 w_sync_err_nxt;

    logic                 w_resync;
    logic                 w_lost;
    logic                 w_store;

    // Classify the accepted sample once; both combinational processes share it.
    always_comb begin
        w_resync = 1'b0;
        w_lost   = 1'b0;
        w_store  = 1'b0;
        if (din_valid && r_state == LOCK) begin
            if (sync && r_slot != 3'd0) begin
                w_resync = 1'b1;
            end else if (!sync && r_slot == 3'd0 && SYNC_CHECK != 0) begin
                w_lost = 1'b1;
            end else begin
                w_store = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= HUNT;
            r_slot        <= '0;
            r_shadow      <= '0;
            r_y           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_shadow      <= w_shadow_nxt;
            r_y           <= w_y_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_sync_err    <= w_sync_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        case (r_state)
            HUNT: begin
                if (din_valid && sync) begin
                    w_state_nxt = LOCK;
                    w_slot_nxt  = 3'd1;
                end
            end
            LOCK: begin
                if (w_resync) begin
                    w_slot_nxt = 3'd1;
                end else if (w_lost) begin
                    w_state_nxt = HUNT;
                    w_slot_nxt  = 3'd0;
                end else if (w_store) begin
                    w_slot_nxt = r_slot + 3'd1;
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_slot_nxt  = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_shadow_nxt      = r_shadow;
        w_y_nxt           = r_y;
        w_frame_valid_nxt = 1'b0;
        w_sync_err_nxt    = 1'b0;
        if (din_valid && r_state == HUNT && sync) begin
            w_shadow_nxt[WIDTH-1:0] = din;
        end
        if (w_resync) begin
            // Stale upper slots are harmless: they are rewritten before slot 7 completes.
            w_shadow_nxt[WIDTH-1:0] = din;
            w_sync_err_nxt          = 1'b1;
        end
        if (w_lost) begin
            w_sync_err_nxt = 1'b1;
        end
        if (w_store) begin
            w_shadow_nxt[32'(r_slot)*WIDTH +: WIDTH] = din;
            if (r_slot == 3'd7) begin
                w_y_nxt           = {din, r_shadow[7*WIDTH-1:0]};
                w_frame_valid_nxt = 1'b1;
            end
        end
    end

    assign s           = r_slot;
    assign locked      = (r_state == LOCK);
    assign y           = r_y;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomised and directed bench for tdm_demux8: two instances (WIDTH=1 with
// sync checking, WIDTH=4 without) run against a frame-collecting reference model.
module tb_tdm_demux8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  din;
    logic        din_valid;
    logic        sync;

    logic [2:0]  s_a, s_b;
    logic        locked_a, locked_b;
    logic [7:0]  y_a;
    logic [31:0] y_b;
    logic        fv_a, fv_b;
    logic        err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, index 0 = instance a, 1 = instance b.
    bit          m_lock [2];
    int          m_cnt  [2];
    logic [3:0]  m_smp  [2][8];
    logic [3:0]  m_lane [2][8];
    bit          m_fv   [2];
    bit          m_err  [2];

    always #5 clk = ~clk;

    tdm_demux8 #(.WIDTH(1), .SYNC_CHECK(1)) u_a (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid), .sync(sync),
        .s(s_a), .locked(locked_a), .y(y_a), .frame_valid(fv_a), .sync_err(err_a)
    );

    tdm_demux8 #(.WIDTH(4), .SYNC_CHECK(0)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .s(s_b), .locked(locked_b), .y(y_b), .frame_valid(fv_b), .sync_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit r, input bit v, input bit sy,
                              input logic [3:0] d, input bit sc);
        m_fv[i]  = 1'b0;
        m_err[i] = 1'b0;
        if (r) begin
            m_lock[i] = 1'b0;
            m_cnt[i]  = 0;
            for (int k = 0; k < 8; k++) m_lane[i][k] = '0;
        end else if (v) begin
            if (!m_lock[i]) begin
                if (sy) begin
                    m_smp[i][0] = d;
                    m_cnt[i]    = 1;
                    m_lock[i]   = 1'b1;
                end
            end else if (sy && m_cnt[i] != 0) begin
                m_err[i]    = 1'b1;
                m_smp[i][0] = d;
                m_cnt[i]    = 1;
            end else if (!sy && m_cnt[i] == 0 && sc) begin
                m_err[i]  = 1'b1;
                m_lock[i] = 1'b0;
            end else begin
                m_smp[i][m_cnt[i]] = d;
                m_cnt[i]++;
                if (m_cnt[i] == 8) begin
                    for (int k = 0; k < 8; k++) m_lane[i][k] = m_smp[i][k];
                    m_fv[i]  = 1'b1;
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0]  exp_a;
        logic [31:0] exp_b;
        for (int k = 0; k < 8; k++) begin
            exp_a[k]       = m_lane[0][k][0];
            exp_b[k*4 +: 4] = m_lane[1][k];
        end
        check("a_s",      32'(s_a),      32'(m_cnt[0]));
        check("a_locked", 32'(locked_a), 32'(m_lock[0]));
        check("a_y",      32'(y_a),      32'(exp_a));
        check("a_fv",     32'(fv_a),     32'(m_fv[0]));
        check("a_err",    32'(err_a),    32'(m_err[0]));
        check("b_s",      32'(s_b),      32'(m_cnt[1]));
        check("b_locked", 32'(locked_b), 32'(m_lock[1]));
        check("b_y",      y_b,           exp_b);
        check("b_fv",     32'(fv_b),     32'(m_fv[1]));
        check("b_err",    32'(err_b),    32'(m_err[1]));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare.
    task automatic cyc(input bit r, input bit v, input bit sy, input logic [3:0] d);
        rst       = r;
        din_valid = v;
        sync      = sy;
        din       = d;
        @(posedge clk);
        model_step(0, r, v, sy, d & 4'h1, 1'b1);
        model_step(1, r, v, sy, d, 1'b0);
        #1;
        compare_all();
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps) cyc(1'b0, 1'b0, 1'b0, 4'($urandom));
            cyc(1'b0, 1'b1, (k == 0), 4'($urandom));
        end
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;

        // Reset for two cycles.
        cyc(1'b1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 1'b1, 1'b1, 4'hF);
        check("rst_y_a", 32'(y_a), 32'h0);
        check("rst_locked_a", 32'(locked_a), 32'h0);

        // Known frame din=1,0,1,1,0,0,1,0 on instance a.
        pat = 8'b0100_1101;
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, (k == 0), {3'b000, pat[k]});
        check("frame1_y_a", 32'(y_a), 32'h4D);
        check("frame1_fv_a", 32'(fv_a), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 4'h0);
        check("frame1_fv_drop", 32'(fv_a), 32'h0);

        // Three back-to-back frames, then one with din_valid toggling.
        repeat (3) send_frame(1'b0);
        send_frame(1'b1);

        // Sync arriving at slot 4 while locked, followed by a full frame from it.
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, (k == 0), 4'($urandom));
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, (k == 0), 4'($urandom));

        // Missing sync at slot 0: a drops to HUNT, b keeps framing.
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 4'($urandom));
        check("nosync_locked_a", 32'(locked_a), 32'h0);
        send_frame(1'b0);

        // Reset at slot 5 with sync and din_valid high.
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, (k == 0), 4'($urandom));
        cyc(1'b1, 1'b1, 1'b1, 4'hF);
        check("midrst_s_a", 32'(s_a), 32'h0);
        check("midrst_y_b", y_b, 32'h0);

        // Random traffic with occasional framing faults and resets.
        for (int n = 0; n < 3000; n++) begin
            bit v, sy, r;
            v  = ($urandom_range(0, 9) < 7);
            sy = (m_cnt[0] == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cyc(r, v, sy, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
